// File: rtl/soc_pll_cfg_seq_if.sv
// Bundles the requester-side and PLL-side signals of the PLL reconfiguration sequencer.
// The sequencer connects through master; the environment connects through slave.
interface soc_pll_cfg_seq_if #(
  parameter int unsigned DATA_W = 32
);
  logic              cfg_req_i;
  logic [DATA_W-1:0] cfg_data_i;
  logic              cfg_gnt_o;
  logic [DATA_W-1:0] soc_pll_config_o;
  logic              soc_pll_config_valid_o;
  logic              soc_pll_config_ready_i;
  logic              soc_clk_en_o;
  logic              busy_o;
  logic              done_o;
  logic              err_o;
  logic [3:0]        retry_cnt_o;

  modport master (
    input  cfg_req_i, cfg_data_i, soc_pll_config_ready_i,
    output cfg_gnt_o, soc_pll_config_o, soc_pll_config_valid_o,
           soc_clk_en_o, busy_o, done_o, err_o, retry_cnt_o
  );

  modport slave (
    output cfg_req_i, cfg_data_i, soc_pll_config_ready_i,
    input  cfg_gnt_o, soc_pll_config_o, soc_pll_config_valid_o,
           soc_clk_en_o, busy_o, done_o, err_o, retry_cnt_o
  );
endinterface

// File: rtl/soc_pll_cfg_seq.sv
// Sequences a PLL reconfiguration: drives the config word with valid/ready, retries with
// back-off on a missing ready, and gates the SoC clock enable until the PLL has settled.
module soc_pll_cfg_seq #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned SETTLE_CYCLES  = 256,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned BACKOFF_CYCLES = 16,
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                clk,
  input  logic                rst,
  soc_pll_cfg_seq_if.master   bus
);

  localparam int unsigned RETRY_W = 4;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_DRIVE   = 2'd1;
  localparam logic [1:0] S_BACKOFF = 2'd2;
  localparam logic [1:0] S_SETTLE  = 2'd3;

  logic [1:0]         state_q,  state_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [DATA_W-1:0]  cfg_q,    cfg_d;
  logic               valid_q,  valid_d;
  logic               clk_en_q, clk_en_d;
  logic               done_q,   done_d;
  logic               err_q,    err_d;
  logic [RETRY_W-1:0] retry_q,  retry_d;
  logic               gnt_c;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      cfg_q    <= '0;
      valid_q  <= 1'b0;
      clk_en_q <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      retry_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cfg_q    <= cfg_d;
      valid_q  <= valid_d;
      clk_en_q <= clk_en_d;
      done_q   <= done_d;
      err_q    <= err_d;
      retry_q  <= retry_d;
    end
  end

  // Next-state and next-output logic; done is a pulse so it defaults low
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cfg_d    = cfg_q;
    valid_d  = valid_q;
    clk_en_d = clk_en_q;
    done_d   = 1'b0;
    err_d    = err_q;
    retry_d  = retry_q;
    gnt_c    = 1'b0;

    case (state_q)
      S_IDLE: begin
        gnt_c = bus.cfg_req_i;
        if (bus.cfg_req_i) begin
          cfg_d    = bus.cfg_data_i;
          err_d    = 1'b0;
          retry_d  = '0;
          clk_en_d = 1'b0;
          valid_d  = 1'b1;
          cnt_d    = '0;
          state_d  = S_DRIVE;
        end
      end

      S_DRIVE: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A handshake on the final timeout cycle still counts as success
        if (bus.soc_pll_config_ready_i) begin
          valid_d = 1'b0;
          cnt_d   = '0;
          state_d = S_SETTLE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          valid_d = 1'b0;
          cnt_d   = '0;
          if (retry_q == RETRY_W'(MAX_RETRY)) begin
            err_d    = 1'b1;
            clk_en_d = 1'b1;
            done_d   = 1'b1;
            state_d  = S_IDLE;
          end else begin
            retry_d = retry_q + RETRY_W'(1);
            state_d = S_BACKOFF;
          end
        end
      end

      S_BACKOFF: begin
        if (cnt_q == CNT_W'(BACKOFF_CYCLES - 1)) begin
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = S_DRIVE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          clk_en_d = 1'b1;
          done_d   = 1'b1;
          cnt_d    = '0;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.cfg_gnt_o              = gnt_c;
  assign bus.soc_pll_config_o       = cfg_q;
  assign bus.soc_pll_config_valid_o = valid_q;
  assign bus.soc_clk_en_o           = clk_en_q;
  assign bus.busy_o                 = (state_q != S_IDLE);
  assign bus.done_o                 = done_q;
  assign bus.err_o                  = err_q;
  assign bus.retry_cnt_o            = retry_q;

endmodule

// File: tb/tb_soc_pll_cfg_seq.sv
// Bench for soc_pll_cfg_seq: vector table, directed multi-cycle sequences, and a randomized
// run compared against a phase/elapsed-cycle reference model.
module tb_soc_pll_cfg_seq;

  localparam int DW  = 32;
  localparam int SET = 8;
  localparam int TO  = 16;
  localparam int BO  = 4;
  localparam int MR  = 2;

  logic clk = 1'b0;
  logic rst;

  soc_pll_cfg_seq_if #(.DATA_W(DW)) bus ();

  soc_pll_cfg_seq #(
    .DATA_W(DW), .SETTLE_CYCLES(SET), .TIMEOUT_CYCLES(TO),
    .BACKOFF_CYCLES(BO), .MAX_RETRY(MR), .CNT_W(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs of one cycle, checked together
  task automatic chk_out(input string nm, input logic v, input logic ce, input logic b,
                         input logic d, input logic e, input logic [3:0] r);
    chk({nm, "_valid"},  32'(bus.soc_pll_config_valid_o), 32'(v));
    chk({nm, "_clk_en"}, 32'(bus.soc_clk_en_o), 32'(ce));
    chk({nm, "_busy"},   32'(bus.busy_o), 32'(b));
    chk({nm, "_done"},   32'(bus.done_o), 32'(d));
    chk({nm, "_err"},    32'(bus.err_o), 32'(e));
    chk({nm, "_retry"},  32'(bus.retry_cnt_o), 32'(r));
  endtask

  task automatic run_expect(input string nm, input int n, input logic v, input logic ce,
                            input logic b, input logic [3:0] r);
    for (int i = 0; i < n; i++) begin
      #1;
      chk_out(nm, v, ce, b, 1'b0, 1'b0, r);
      step();
    end
  endtask

  task automatic do_reset(input string nm);
    rst = 1'b1;
    bus.cfg_req_i = 1'b0;
    bus.soc_pll_config_ready_i = 1'b0;
    step();
    rst = 1'b0;
    #1;
    chk_out(nm, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    chk({nm, "_cfg"}, bus.soc_pll_config_o, 32'h0);
    chk({nm, "_gnt"}, 32'(bus.cfg_gnt_o), 32'h0);
    step();
  endtask

  task automatic grant(input string nm, input logic [31:0] d);
    bus.cfg_req_i = 1'b1;
    bus.cfg_data_i = d;
    bus.soc_pll_config_ready_i = 1'b0;
    #1;
    chk({nm, "_gnt"}, 32'(bus.cfg_gnt_o), 32'h1);
    step();
    bus.cfg_req_i = 1'b0;
  endtask

  typedef struct {
    logic        req;
    logic [31:0] data;
    logic        ready;
    logic        gnt, valid, clk_en, busy, done;
    logic [31:0] cfg;
  } vec_t;

  function automatic vec_t mk(logic req, logic [31:0] data, logic ready, logic gnt, logic valid,
                              logic clk_en, logic busy, logic done, logic [31:0] cfg);
    vec_t t;
    t.req = req; t.data = data; t.ready = ready; t.gnt = gnt; t.valid = valid;
    t.clk_en = clk_en; t.busy = busy; t.done = done; t.cfg = cfg;
    return t;
  endfunction

  // Reference model: which phase the sequence is in and how many cycles spent there
  typedef enum int {M_IDLE, M_DRV, M_BO, M_SET} mph_e;
  mph_e        m_ph;
  int          m_n;
  logic [31:0] m_cfg;
  logic        m_err, m_done;
  int          m_retry;

  function automatic void m_reset();
    m_ph = M_IDLE; m_n = 0; m_cfg = '0; m_err = 1'b0; m_done = 1'b0; m_retry = 0;
  endfunction

  function automatic void m_edge(logic r, logic req, logic [31:0] d, logic rdy);
    if (r) begin
      m_reset();
      return;
    end
    m_done = 1'b0;
    case (m_ph)
      M_IDLE: if (req) begin
        m_cfg = d; m_err = 1'b0; m_retry = 0; m_ph = M_DRV; m_n = 1;
      end
      M_DRV: begin
        if (rdy) begin
          m_ph = M_SET; m_n = 1;
        end else if (m_n == TO) begin
          if (m_retry == MR) begin
            m_err = 1'b1; m_done = 1'b1; m_ph = M_IDLE;
          end else begin
            m_retry++; m_ph = M_BO; m_n = 1;
          end
        end else m_n++;
      end
      M_BO: if (m_n == BO) begin m_ph = M_DRV; m_n = 1; end else m_n++;
      M_SET: if (m_n == SET) begin m_ph = M_IDLE; m_done = 1'b1; end else m_n++;
      default: m_reset();
    endcase
  endfunction

  vec_t tbl[15];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.cfg_req_i = 1'b0;
    bus.cfg_data_i = '0;
    bus.soc_pll_config_ready_i = 1'b0;

    //           req  data          rdy  gnt  v    ce   busy done cfg
    tbl[0]  = mk(1'b1, 32'h0000_1234, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    tbl[1]  = mk(1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1234);
    tbl[2]  = mk(1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1234);
    tbl[3]  = mk(1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1234);
    tbl[4]  = mk(1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1234);
    tbl[5]  = mk(1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1234);
    tbl[6]  = mk(1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1234);
    tbl[7]  = mk(1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1234);
    tbl[8]  = mk(1'b1, 32'h0000_ABCD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1234);
    tbl[9]  = mk(1'b1, 32'h0000_ABCD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1234);
    tbl[10] = mk(1'b1, 32'h0000_ABCD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1234);
    tbl[11] = mk(1'b1, 32'h0000_ABCD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1234);
    tbl[12] = mk(1'b1, 32'h0000_ABCD, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1234);
    tbl[13] = mk(1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_ABCD);
    tbl[14] = mk(1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_ABCD);

    do_reset("reset");

    // Basic handshake, ignored ready in SETTLE, request held while busy
    for (int i = 0; i < 15; i++) begin
      bus.cfg_req_i = tbl[i].req;
      bus.cfg_data_i = tbl[i].data;
      bus.soc_pll_config_ready_i = tbl[i].ready;
      #1;
      chk($sformatf("tbl%0d_gnt", i),    32'(bus.cfg_gnt_o), 32'(tbl[i].gnt));
      chk($sformatf("tbl%0d_valid", i),  32'(bus.soc_pll_config_valid_o), 32'(tbl[i].valid));
      chk($sformatf("tbl%0d_clk_en", i), 32'(bus.soc_clk_en_o), 32'(tbl[i].clk_en));
      chk($sformatf("tbl%0d_busy", i),   32'(bus.busy_o), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d_done", i),   32'(bus.done_o), 32'(tbl[i].done));
      chk($sformatf("tbl%0d_err", i),    32'(bus.err_o), 32'h0);
      chk($sformatf("tbl%0d_retry", i),  32'(bus.retry_cnt_o), 32'h0);
      chk($sformatf("tbl%0d_cfg", i),    bus.soc_pll_config_o, tbl[i].cfg);
      step();
    end

    do_reset("rst_settle");

    // Single retry: 16 valid, 4 idle, then handshake on cycle 2 of attempt 2
    grant("retry1", 32'h0000_0777);
    run_expect("retry1_att0", TO, 1'b1, 1'b0, 1'b1, 4'd0);
    run_expect("retry1_bo",   BO, 1'b0, 1'b0, 1'b1, 4'd1);
    run_expect("retry1_att1", 1,  1'b1, 1'b0, 1'b1, 4'd1);
    bus.soc_pll_config_ready_i = 1'b1;
    run_expect("retry1_hs",   1,  1'b1, 1'b0, 1'b1, 4'd1);
    bus.soc_pll_config_ready_i = 1'b0;
    run_expect("retry1_set",  SET, 1'b0, 1'b0, 1'b1, 4'd1);
    #1;
    chk_out("retry1_done", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1);
    chk("retry1_cfg", bus.soc_pll_config_o, 32'h0000_0777);
    step();
    #1;
    chk("retry1_done_clr", 32'(bus.done_o), 32'h0);
    step();

    // Exhaustion: three unanswered attempts, then error
    grant("exh", 32'h0000_0BAD);
    for (int a = 0; a <= MR; a++) begin
      run_expect($sformatf("exh_att%0d", a), TO, 1'b1, 1'b0, 1'b1, 4'(a));
      if (a < MR) run_expect($sformatf("exh_bo%0d", a), BO, 1'b0, 1'b0, 1'b1, 4'(a + 1));
    end
    #1;
    chk_out("exh_done", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd2);
    step();
    #1;
    chk_out("exh_sticky", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2);
    grant("regrant", 32'h5555_0000);
    #1;
    chk_out("regrant", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    chk("regrant_cfg", bus.soc_pll_config_o, 32'h5555_0000);
    step();

    do_reset("rst_drive");

    // Ready on the last cycle of an attempt wins over the timeout
    grant("simul", 32'h0000_0C0C);
    run_expect("simul_att", TO - 1, 1'b1, 1'b0, 1'b1, 4'd0);
    bus.soc_pll_config_ready_i = 1'b1;
    run_expect("simul_hs", 1, 1'b1, 1'b0, 1'b1, 4'd0);
    bus.soc_pll_config_ready_i = 1'b0;
    run_expect("simul_set", SET, 1'b0, 1'b0, 1'b1, 4'd0);
    #1;
    chk_out("simul_done", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    step();

    // Randomized traffic against the reference model
    do_reset("rnd_start");
    m_reset();
    for (int c = 0; c < 1500; c++) begin
      logic exp_gnt;
      rst = ($urandom_range(0, 399) == 0);
      if (!bus.cfg_req_i && $urandom_range(0, 5) == 0) begin
        bus.cfg_req_i = 1'b1;
        bus.cfg_data_i = $urandom;
      end
      bus.soc_pll_config_ready_i = ($urandom_range(0, 19) == 0);
      #1;
      exp_gnt = (m_ph == M_IDLE) && bus.cfg_req_i;
      chk("rnd_gnt",    32'(bus.cfg_gnt_o), 32'(exp_gnt));
      chk("rnd_valid",  32'(bus.soc_pll_config_valid_o), 32'(m_ph == M_DRV));
      chk("rnd_clk_en", 32'(bus.soc_clk_en_o), 32'(m_ph == M_IDLE));
      chk("rnd_busy",   32'(bus.busy_o), 32'(m_ph != M_IDLE));
      chk("rnd_done",   32'(bus.done_o), 32'(m_done));
      chk("rnd_err",    32'(bus.err_o), 32'(m_err));
      chk("rnd_retry",  32'(bus.retry_cnt_o), 32'(m_retry));
      chk("rnd_cfg",    bus.soc_pll_config_o, m_cfg);
      m_edge(rst, bus.cfg_req_i, bus.cfg_data_i, bus.soc_pll_config_ready_i);
      step();
      if (exp_gnt && !rst) bus.cfg_req_i = 1'b0;
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
